// File: rtl/tmds_encoder.sv
// DC-balancing stage of a TMDS channel encoder: turns the 9-bit transition-minimized
// word into a registered 10-bit symbol while steering the running disparity toward zero.
module tmds_encoder #(
    parameter int TALLY_WIDTH = 5
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [8:0]             qm_in,
    input  logic                   ve_in,
    input  logic [1:0]             control_in,
    output logic [9:0]             tmds_out,
    output logic [TALLY_WIDTH-1:0] tally_out
);

    localparam int TW = TALLY_WIDTH;
    localparam logic signed [TW-1:0] EIGHT = TW'(8);
    localparam logic signed [TW-1:0] TWO   = TW'(2);

    logic [3:0]           w_n1;
    logic signed [TW-1:0] w_n1x2;
    logic signed [TW-1:0] w_diff;
    logic signed [TW-1:0] w_two_q8;
    logic signed [TW-1:0] w_two_nq8;
    logic signed [TW-1:0] w_tally_next;
    logic signed [TW-1:0] r_tally;
    logic [9:0]           w_sym;
    logic [9:0]           r_tmds;
    logic                 w_tally_zero;
    logic                 w_tally_neg;
    logic                 w_case_a;
    logic                 w_case_b;

    always_comb begin
        w_n1 = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_n1 = w_n1 + {3'd0, qm_in[i]};
        end
    end

    // w_diff is n1 - n0, i.e. 2*n1 - 8
    assign w_n1x2       = TW'({w_n1, 1'b0});
    assign w_diff       = w_n1x2 - EIGHT;
    assign w_two_q8     = qm_in[8] ? TWO : '0;
    assign w_two_nq8    = qm_in[8] ? '0 : TWO;
    assign w_tally_zero = (r_tally == '0);
    assign w_tally_neg  = r_tally[TW-1];
    assign w_case_a     = w_tally_zero || (w_n1 == 4'd4);
    assign w_case_b     = (!w_tally_neg && (w_n1 > 4'd4)) || (w_tally_neg && (w_n1 < 4'd4));

    always_comb begin
        w_sym        = '0;
        w_tally_next = '0;
        if (!ve_in) begin
            case (control_in)
                2'b00:   w_sym = 10'b1101010100;
                2'b01:   w_sym = 10'b0010101011;
                2'b10:   w_sym = 10'b0101010100;
                default: w_sym = 10'b1010101011;
            endcase
        end else if (w_case_a) begin
            w_sym        = {~qm_in[8], qm_in[8], qm_in[8] ? qm_in[7:0] : ~qm_in[7:0]};
            w_tally_next = qm_in[8] ? (r_tally + w_diff) : (r_tally - w_diff);
        end else if (w_case_b) begin
            // Invert the data byte to pull the disparity back toward zero
            w_sym        = {1'b1, qm_in[8], ~qm_in[7:0]};
            w_tally_next = r_tally + w_two_q8 - w_diff;
        end else begin
            w_sym        = {1'b0, qm_in[8], qm_in[7:0]};
            w_tally_next = r_tally - w_two_nq8 + w_diff;
        end
    end

    // Free-running: one symbol per clock, no handshake.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_tmds  <= '0;
            r_tally <= '0;
        end else begin
            r_tmds  <= w_sym;
            r_tally <= w_tally_next;
        end
    end

    assign tmds_out  = r_tmds;
    assign tally_out = r_tally;

endmodule

// File: tb/tb_tmds_encoder.sv
// Scoreboard bench for tmds_encoder: directed vectors with literal expectations,
// then a long random run checked against an independent behavioural model.
module tb_tmds_encoder;

    localparam int TW = 5;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [8:0]    qm_in;
    logic          ve_in;
    logic [1:0]    control_in;
    logic [9:0]    tmds_out;
    logic [TW-1:0] tally_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Entry layout: {video, tmds[9:0], tally[4:0]}
    logic [15:0] exp_q[$];

    int            m_tally = 0;
    int            cum_disp = 0;
    logic          prev_ve = 1'b0;
    logic [TW-1:0] prev_tally = '0;

    tmds_encoder #(.TALLY_WIDTH(TW)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .qm_in      (qm_in),
        .ve_in      (ve_in),
        .control_in (control_in),
        .tmds_out   (tmds_out),
        .tally_out  (tally_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural reference: updates m_tally and returns the symbol.
    task automatic model_step(input logic rst, input logic ve, input logic [1:0] ctrl,
                              input logic [8:0] qm, output logic [9:0] sym);
        int n1, n0, q8;
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        q8 = int'(qm[8]);
        if (rst) begin
            sym = 10'h000;
            m_tally = 0;
        end else if (!ve) begin
            case (ctrl)
                2'b00:   sym = 10'h354;
                2'b01:   sym = 10'h0AB;
                2'b10:   sym = 10'h154;
                default: sym = 10'h2AB;
            endcase
            m_tally = 0;
        end else if (m_tally == 0 || n1 == 4) begin
            sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            m_tally = m_tally + (q8 == 1 ? (n1 - n0) : (n0 - n1));
        end else if ((m_tally > 0 && n1 > 4) || (m_tally < 0 && n1 < 4)) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            m_tally = m_tally + 2 * q8 + (n0 - n1);
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            m_tally = m_tally - 2 * (1 - q8) + (n1 - n0);
        end
    endtask

    task automatic monitor_pop();
        logic [15:0] e;
        int          t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("tmds", 16'(tmds_out), 16'(e[14:5]));
            check_eq("tally", 16'(tally_out), 16'(e[4:0]));
            t = int'($signed(tally_out));
            check_eq("tally_range", 16'(t >= -8 && t <= 8), 16'd1);
            if (e[15]) begin
                cum_disp   = cum_disp + 2 * $countones(tmds_out) - 10;
                prev_ve    = 1'b1;
                prev_tally = e[4:0];
            end else begin
                if (prev_ve)
                    check_eq("period_disp", 16'(cum_disp), 16'(int'($signed(prev_tally))));
                cum_disp = 0;
                prev_ve  = 1'b0;
            end
        end
    endtask

    // use_exp=1 pushes the literal expectation; the model still advances to stay in sync.
    task automatic step(input logic rst, input logic ve, input logic [1:0] ctrl, input logic [8:0] qm,
                        input logic use_exp, input logic [9:0] x_tmds, input int x_tally);
        logic [9:0] sym;
        @(negedge clk_in);
        monitor_pop();
        rst_in     = rst;
        ve_in      = ve;
        control_in = ctrl;
        qm_in      = qm;
        model_step(rst, ve, ctrl, qm, sym);
        if (use_exp)
            exp_q.push_back({ve & ~rst, x_tmds, TW'(x_tally)});
        else
            exp_q.push_back({ve & ~rst, sym, TW'(m_tally)});
    endtask

    initial begin
        logic [3:0] ctrl_vals[4];
        rst_in     = 1'b1;
        ve_in      = 1'b1;
        control_in = 2'b00;
        qm_in      = 9'h1FF;

        step(1'b1, 1'b1, 2'b00, 9'h1FF, 1'b1, 10'h000, 0);
        step(1'b1, 1'b1, 2'b00, 9'h1FF, 1'b1, 10'h000, 0);

        step(1'b0, 1'b0, 2'b00, 9'h1FF, 1'b1, 10'h354, 0);
        step(1'b0, 1'b0, 2'b01, 9'h0A5, 1'b1, 10'h0AB, 0);
        step(1'b0, 1'b0, 2'b10, 9'h100, 1'b1, 10'h154, 0);
        step(1'b0, 1'b0, 2'b11, 9'h033, 1'b1, 10'h2AB, 0);

        step(1'b0, 1'b1, 2'b00, 9'h100, 1'b1, 10'h100, -8);
        step(1'b0, 1'b1, 2'b00, 9'h100, 1'b1, 10'h3FF, 2);
        step(1'b0, 1'b1, 2'b00, 9'h00F, 1'b1, 10'h2F0, 2);
        step(1'b0, 1'b1, 2'b00, 9'h101, 1'b1, 10'h101, -4);
        step(1'b0, 1'b0, 2'b00, 9'h000, 1'b1, 10'h354, 0);

        // Reset in the middle of a video stream, then resume.
        step(1'b0, 1'b1, 2'b00, 9'h0FF, 1'b0, 10'h000, 0);
        step(1'b1, 1'b1, 2'b10, 9'h0FF, 1'b0, 10'h000, 0);
        step(1'b0, 1'b1, 2'b00, 9'h0FF, 1'b0, 10'h000, 0);

        for (int i = 0; i < 10000; i++) begin
            step(1'b0, ($urandom_range(0, 19) != 0), 2'($urandom_range(0, 3)),
                 9'($urandom_range(0, 511)), 1'b0, 10'h000, 0);
        end

        step(1'b0, 1'b0, 2'b00, 9'h000, 1'b0, 10'h000, 0);
        @(negedge clk_in);
        monitor_pop();
        check_eq("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
